// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the CPU instruction FSM:
// memory command encodings, arbiter owner states and default bus widths.
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 16;

  // Memory command issued by the CPU FSM; 2'b11 is illegal and acts as MNONE
  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } m_cmd_e;

  // Which requester currently drives the RAM port
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // True only for the two legal commands that actually touch memory
  function automatic logic cmd_active(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// The flag stays high once the count reaches TC, so a counter parked at its
// saturation value still reports terminal count.
module arb_sat_counter #(
  parameter int SAT = 8,
  parameter int TC  = SAT - 1,
  parameter int W   = $clog2(SAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] count;

  // Count register: clear wins over increment, increment stops at SAT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(SAT))) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count >= W'(TC));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port program/data RAM between the CPU
// instruction FSM and the program-loader/debug port. The CPU is stalled
// while the loader owns memory; a wait counter bounds how long the loader
// queues behind CPU traffic and a burst counter bounds how long the CPU
// queues behind the loader.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 8,
  parameter int MAX_WAIT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  owner_e owner, owner_next;
  logic   cpu_active;
  logic   ldr_beat;
  logic   burst_clr, burst_inc, burst_tc;
  logic   wait_clr, wait_inc, wait_tc;

  assign cpu_active = cmd_active(cpu_cmd);
  assign ldr_beat   = (owner == OWN_LDR) && ldr_req;

  arb_sat_counter #(.SAT(MAX_BURST), .TC(MAX_BURST - 1)) u_burst (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .tc    (burst_tc)
  );

  arb_sat_counter #(.SAT(MAX_WAIT), .TC(MAX_WAIT - 1)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .tc    (wait_tc)
  );

  // Owner register; reset hands memory back to the CPU without a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= OWN_CPU;
    end else begin
      owner <= owner_next;
    end
  end

  // Next owner plus burst/wait counter control
  always_comb begin
    owner_next = owner;
    burst_clr  = 1'b0;
    burst_inc  = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    case (owner)
      OWN_CPU: begin
        burst_clr = 1'b1;
        if (!ldr_req) begin
          wait_clr = 1'b1;
        end else if (!cpu_active || wait_tc) begin
          owner_next = OWN_LDR;
          wait_clr   = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      OWN_LDR: begin
        wait_clr = 1'b1;
        if (!ldr_req) begin
          owner_next = OWN_CPU;
        end else if (burst_tc && cpu_active) begin
          owner_next = OWN_CPU;
          burst_clr  = 1'b1;
        end else begin
          burst_inc = 1'b1;
        end
      end
      default: owner_next = OWN_CPU;
    endcase
  end

  // RAM port mux; a CPU write is suppressed while reset is held low
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = reset && (cpu_cmd == MWRITE);
    cpu_stall = 1'b0;
    ldr_gnt   = 1'b0;
    if (owner == OWN_LDR) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_req && ldr_we;
      cpu_stall = 1'b1;
      ldr_gnt   = ldr_req;
    end
  end

  // Loader read-data valid, one cycle after a granted read beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldr_rvalid <= 1'b0;
    end else begin
      ldr_rvalid <= ldr_beat && !ldr_we;
    end
  end

  assign cpu_rdata = ram_rdata;
  assign ldr_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural RAM with one-cycle read
// latency sits on the RAM port. Loader beats and loader read data are checked
// through scoreboard queues filled by the stimulus and drained by a monitor;
// per-cycle arbitration behaviour is checked directly in the stimulus thread.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic          ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } beat_t;

  beat_t         gnt_q[$];
  logic [DW-1:0] rd_q[$];
  beat_t         exp_beat;
  logic [DW-1:0] exp_rd;

  logic [DW-1:0] ram_array [256];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8), .MAX_WAIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_cmd    (cpu_cmd),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM preload: every word holds 16'h1000 + address
  initial begin
    for (int i = 0; i < 256; i++) ram_array[i] = 16'h1000 + 16'(i);
  end

  // Synchronous RAM model, read-before-write, one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) ram_array[ram_addr] <= ram_wdata;
    ram_rdata <= ram_array[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkCycle(input string tag, input logic exp_gnt, input logic exp_stall, input logic exp_we);
    checkOutput({tag, ".gnt"},   16'(ldr_gnt),   16'(exp_gnt));
    checkOutput({tag, ".stall"}, 16'(cpu_stall), 16'(exp_stall));
    checkOutput({tag, ".we"},    16'(ram_we),    16'(exp_we));
  endtask

  task automatic pushBeat(input logic [7:0] a, input logic w, input logic [15:0] d);
    beat_t b;
    b.addr  = a;
    b.we    = w;
    b.wdata = d;
    gnt_q.push_back(b);
  endtask

  // Drive one cycle of inputs just after the rising edge, return mid-cycle
  task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] caddr, input logic [15:0] cwdata,
                               input logic lreq, input logic lwe, input logic [7:0] laddr,
                               input logic [15:0] lwdata);
    @(posedge clk);
    #1;
    cpu_cmd   = cmd;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
    ldr_req   = lreq;
    ldr_we    = lwe;
    ldr_addr  = laddr;
    ldr_wdata = lwdata;
    #2;
  endtask

  // Monitor: every granted beat and every loader read return is scored
  always @(negedge clk) begin
    if (reset) begin
      if (ldr_gnt) begin
        if (gnt_q.size() == 0) begin
          checkOutput("gnt_unexpected", 16'(ldr_gnt), 16'd0);
        end else begin
          exp_beat = gnt_q.pop_front();
          checkOutput("sb_addr",  16'(ram_addr), 16'(exp_beat.addr));
          checkOutput("sb_we",    16'(ram_we),   16'(exp_beat.we));
          checkOutput("sb_wdata", ram_wdata,     exp_beat.wdata);
        end
      end
      if (ldr_rvalid) begin
        if (rd_q.size() == 0) begin
          checkOutput("rvalid_unexpected", 16'(ldr_rvalid), 16'd0);
        end else begin
          exp_rd = rd_q.pop_front();
          checkOutput("sb_rdata", ldr_rdata, exp_rd);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cpu_cmd   = MWRITE;
    cpu_addr  = 8'h05;
    cpu_wdata = 16'hFFFF;
    ldr_req   = 1'b0;
    ldr_we    = 1'b0;
    ldr_addr  = 8'h00;
    ldr_wdata = 16'h0000;

    // Reset state, with a CPU write presented that must not reach the RAM
    #13;
    checkOutput("rst_stall",  16'(cpu_stall),  16'd0);
    checkOutput("rst_gnt",    16'(ldr_gnt),    16'd0);
    checkOutput("rst_rvalid", 16'(ldr_rvalid), 16'd0);
    checkOutput("rst_we",     16'(ram_we),     16'd0);
    @(negedge clk);
    cpu_cmd = MNONE;
    reset   = 1'b1;

    // CPU read of 05, then a write/read-back of 20
    applyStimulus(MREAD, 8'h05, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("cpu_rd_addr", 16'(ram_addr), 16'h0005);
    checkCycle("cpu_rd", 1'b0, 1'b0, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("cpu_rdata05", cpu_rdata, 16'h1005);
    applyStimulus(MWRITE, 8'h20, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("cpu_wr", 1'b0, 1'b0, 1'b1);
    checkOutput("cpu_wr_data", ram_wdata, 16'hBEEF);
    applyStimulus(MREAD, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("cpu_rdata20", cpu_rdata, 16'hBEEF);

    // Loader write burst 10..13 while the CPU is idle
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10, 16'hA000);
    checkCycle("wr_arb", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) pushBeat(8'h10 + 8'(k), 1'b1, 16'hA000 + 16'(k));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10 + 8'(k), 16'hA000 + 16'(k));
      checkCycle("wr_beat", 1'b1, 1'b1, 1'b1);
    end
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("wr_handoff", 1'b0, 1'b1, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("wr_back", 1'b0, 1'b0, 1'b0);

    // Single loader read of 10
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    checkCycle("rd_arb", 1'b0, 1'b0, 1'b0);
    pushBeat(8'h10, 1'b0, 16'h0000);
    rd_q.push_back(16'hA000);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    checkCycle("rd_gnt", 1'b1, 1'b1, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rd_rvalid", 16'(ldr_rvalid), 16'd1);
    checkOutput("rd_rdata", ldr_rdata, 16'hA000);
    checkCycle("rd_handoff", 1'b0, 1'b1, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rd_rvalid_off", 16'(ldr_rvalid), 16'd0);

    // Forced preemption: 16 CPU reads with the loader waiting
    pushBeat(8'h10, 1'b0, 16'h0000);
    pushBeat(8'h11, 1'b0, 16'h0000);
    rd_q.push_back(16'hA000);
    rd_q.push_back(16'hA001);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(MREAD, 8'h30 + 8'(i), 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
      checkOutput("pre_wait_gnt", 16'(ldr_gnt), 16'd0);
      checkOutput("pre_wait_stall", 16'(cpu_stall), 16'd0);
      if (i > 0) checkOutput("pre_cpu_rdata", cpu_rdata, 16'h1030 + 16'(i - 1));
    end
    applyStimulus(MWRITE, 8'h50, 16'hD00D, 1'b1, 1'b0, 8'h10, 16'h0000);
    checkCycle("pre_beat0", 1'b1, 1'b1, 1'b0);
    checkOutput("pre_beat0_addr", 16'(ram_addr), 16'h0010);
    applyStimulus(MWRITE, 8'h50, 16'hD00D, 1'b1, 1'b0, 8'h11, 16'h0000);
    checkCycle("pre_beat1", 1'b1, 1'b1, 1'b0);
    applyStimulus(MWRITE, 8'h50, 16'hD00D, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("pre_handoff", 1'b0, 1'b1, 1'b0);
    applyStimulus(MWRITE, 8'h50, 16'hD00D, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("pre_cpu_wr", 1'b0, 1'b0, 1'b1);
    applyStimulus(MREAD, 8'h50, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("pre_rdata50", cpu_rdata, 16'hD00D);

    // Loader burst with the CPU reading: yield after 8 beats
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h70, 16'hE000);
    checkCycle("bur_arb", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) pushBeat(8'h70 + 8'(k), 1'b1, 16'hE000 + 16'(k));
    for (int k = 0; k < 8; k++) begin
      applyStimulus(MREAD, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h70 + 8'(k), 16'hE000 + 16'(k));
      checkCycle("bur_beat", 1'b1, 1'b1, 1'b1);
    end
    applyStimulus(MREAD, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h78, 16'hE008);
    checkCycle("bur_yield", 1'b0, 1'b0, 1'b0);
    checkOutput("bur_yield_addr", 16'(ram_addr), 16'h0060);
    pushBeat(8'h78, 1'b1, 16'hE008);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h78, 16'hE008);
    checkOutput("bur_cpu_rdata", cpu_rdata, 16'h1060);
    checkCycle("bur_rearb", 1'b0, 1'b0, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h78, 16'hE008);
    checkCycle("bur_regrant", 1'b1, 1'b1, 1'b1);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("bur_handoff", 1'b0, 1'b1, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Loader read burst interrupted by reset on beat 3
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    checkCycle("rst_arb", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pushBeat(8'h10 + 8'(k), 1'b0, 16'h0000);
    rd_q.push_back(16'hA000);
    rd_q.push_back(16'hA001);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(MNONE, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10 + 8'(k), 16'h0000);
      checkCycle("rst_beat", 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(MNONE, 8'h44, 16'h0000, 1'b1, 1'b0, 8'h13, 16'h0000);
    checkOutput("rst_beat3_gnt", 16'(ldr_gnt), 16'd1);
    checkOutput("rst_beat3_rvalid", 16'(ldr_rvalid), 16'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_gnt", 16'(ldr_gnt), 16'd0);
    checkOutput("rst_mid_rvalid", 16'(ldr_rvalid), 16'd0);
    checkOutput("rst_mid_stall", 16'(cpu_stall), 16'd0);
    checkOutput("rst_mid_addr", 16'(ram_addr), 16'h0044);
    cpu_cmd = MWRITE;
    ldr_req = 1'b0;
    #1;
    checkOutput("rst_mid_we", 16'(ram_we), 16'd0);
    @(negedge clk);
    cpu_cmd = MNONE;
    reset   = 1'b1;

    // Illegal command 2'b11 behaves as an idle CPU
    applyStimulus(2'b11, 8'h44, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("ill_idle", 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 8'h44, 16'h1234, 1'b1, 1'b1, 8'h90, 16'hF00F);
    checkCycle("ill_arb", 1'b0, 1'b0, 1'b0);
    pushBeat(8'h90, 1'b1, 16'hF00F);
    applyStimulus(2'b11, 8'h44, 16'h1234, 1'b1, 1'b1, 8'h90, 16'hF00F);
    checkCycle("ill_gnt", 1'b1, 1'b1, 1'b1);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkCycle("ill_handoff", 1'b0, 1'b1, 1'b0);
    applyStimulus(MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clk);
    #1;

    // Every expected beat and read return must have been consumed
    checkOutput("gnt_q_left", 16'(gnt_q.size()), 16'd0);
    checkOutput("rd_q_left",  16'(rd_q.size()),  16'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
